// File: rtl/costas_pkg.sv
// Shared definitions for the Costas carrier-recovery loop: detector modes,
// wide saturating arithmetic helpers and lock-counter sizing.
package costas_pkg;

   typedef enum logic {
      MODE_QPSK = 1'b0,
      MODE_BPSK = 1'b1
   } mode_e;

   // Wide enough to hold any FW+2 intermediate sum without overflow.
   localparam int WIDE = 128;
   typedef logic signed [WIDE-1:0] wide_t;

   function automatic wide_t sat_limit(input int w);
      return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
      wide_t sum;
      wide_t lim;
      sum = a + b;
      lim = sat_limit(w);
      if (sum > lim) begin
         sum = lim;
      end else if (sum < -lim) begin
         sum = -lim;
      end
      return sum;
   endfunction

   function automatic wide_t sext_shift(input wide_t x, input int sh);
      return x >>> sh;
   endfunction

   function automatic int lock_cnt_width(input int lockCnt, input int unlockCnt);
      return $clog2(((lockCnt > unlockCnt) ? lockCnt : unlockCnt) + 1);
   endfunction

endpackage

// File: rtl/costas_pi_filter.sv
// Shift-gain PI loop filter with a symmetric saturating integrator; the
// registered offset is the frequency correction subtracted from the carrier.
module costas_pi_filter
   import costas_pkg::*;
#(
   parameter int FW       = 32,
   parameter int KP_SHIFT = 7,
   parameter int KI_SHIFT = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              err_valid_i,
   input  logic signed [FW:0] err_i,
   input  logic              freeze_i,
   input  logic              clear_i,
   output logic [FW-1:0]     offset_o
);

   logic signed [FW-1:0] integ_d, integ_q;
   logic signed [FW-1:0] offset_d, offset_q;
   wide_t                errW, propW, integNext;

   // Offset uses the freshly updated integrator so a step in error shows up
   // in both paths on the same sample; freeze drops prop and holds integ.
   always_comb begin
      errW      = wide_t'(err_i);
      propW     = sext_shift(errW, KP_SHIFT);
      integNext = sat_add(wide_t'(integ_q), sext_shift(errW, KI_SHIFT), FW);
      integ_d   = integ_q;
      offset_d  = offset_q;
      if (clear_i) begin
         integ_d  = '0;
         offset_d = '0;
      end else if (err_valid_i) begin
         if (freeze_i) begin
            offset_d = integ_q;
         end else begin
            integ_d  = FW'(integNext);
            offset_d = FW'(sat_add(propW, integNext, FW));
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         integ_q  <= '0;
         offset_q <= '0;
      end else begin
         integ_q  <= integ_d;
         offset_q <= offset_d;
      end
   end

   assign offset_o = offset_q;

endmodule

// File: rtl/costas_loop_gen.sv
// Costas carrier-recovery loop: decision-directed phase detector, PI filter,
// corrected FCW, free-running NCO phase accumulator and hysteretic lock flag.
module costas_loop_gen
   import costas_pkg::*;
#(
   parameter int DW         = 32,
   parameter int FW         = 32,
   parameter int KP_SHIFT   = 7,
   parameter int KI_SHIFT   = 12,
   parameter int LOCK_CNT   = 64,
   parameter int UNLOCK_CNT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic signed [DW-1:0] i_in,
   input  logic signed [DW-1:0] q_in,
   input  logic              mode,
   input  logic [FW-1:0]     center_freq,
   input  logic [DW-1:0]     lock_thresh,
   input  logic              freeze,
   input  logic              clear,
   output logic [FW-1:0]     carrier_freq_out,
   output logic [FW-1:0]     nco_phase,
   output logic              err_valid,
   output logic signed [DW:0] phase_err,
   output logic              locked
);

   localparam int CW = lock_cnt_width(LOCK_CNT, UNLOCK_CNT);

   logic signed [DW:0] iExt, qExt, qTerm, iTerm;
   logic signed [DW:0] phaseErr_d, phaseErr_q;
   logic               errValid_q;
   logic signed [FW:0] errExt;
   logic [FW-1:0]      offset;
   logic [FW-1:0]      ncoPhase_q;
   logic [DW:0]        absErr;
   logic               inThresh;
   logic [CW-1:0]      lockTarget;
   logic [CW-1:0]      lockCnt_d, lockCnt_q;
   logic               locked_d, locked_q;

   // One extra bit keeps negating the most negative input and the QPSK
   // difference exact.
   always_comb begin
      iExt  = {i_in[DW-1], i_in};
      qExt  = {q_in[DW-1], q_in};
      qTerm = i_in[DW-1] ? -qExt : qExt;
      iTerm = q_in[DW-1] ? -iExt : iExt;
      phaseErr_d = (mode_e'(mode) == MODE_BPSK) ? qTerm : qTerm - iTerm;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phaseErr_q <= '0;
         errValid_q <= 1'b0;
      end else begin
         errValid_q <= in_valid;
         if (in_valid) begin
            phaseErr_q <= phaseErr_d;
         end
      end
   end

   assign errExt = (FW+1)'(wide_t'(phaseErr_q));

   costas_pi_filter #(
      .FW       (FW),
      .KP_SHIFT (KP_SHIFT),
      .KI_SHIFT (KI_SHIFT)
   ) u_pi_filter (
      .clk         (clk),
      .reset       (reset),
      .err_valid_i (errValid_q),
      .err_i       (errExt),
      .freeze_i    (freeze),
      .clear_i     (clear),
      .offset_o    (offset)
   );

   assign carrier_freq_out = center_freq - offset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ncoPhase_q <= '0;
      end else begin
         ncoPhase_q <= ncoPhase_q + carrier_freq_out;
      end
   end

   // The counter measures a run of samples disagreeing with the current lock
   // state; any agreeing sample restarts the run, which gives the hysteresis.
   always_comb begin
      absErr     = phaseErr_q[DW] ? unsigned'(-phaseErr_q) : unsigned'(phaseErr_q);
      inThresh   = absErr < {1'b0, lock_thresh};
      lockTarget = locked_q ? CW'(UNLOCK_CNT - 1) : CW'(LOCK_CNT - 1);
      lockCnt_d  = lockCnt_q;
      locked_d   = locked_q;
      if (clear) begin
         lockCnt_d = '0;
         locked_d  = 1'b0;
      end else if (errValid_q) begin
         if (inThresh != locked_q) begin
            if (lockCnt_q == lockTarget) begin
               lockCnt_d = '0;
               locked_d  = ~locked_q;
            end else begin
               lockCnt_d = lockCnt_q + CW'(1);
            end
         end else begin
            lockCnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lockCnt_q <= '0;
         locked_q  <= 1'b0;
      end else begin
         lockCnt_q <= lockCnt_d;
         locked_q  <= locked_d;
      end
   end

   assign nco_phase = ncoPhase_q;
   assign err_valid = errValid_q;
   assign phase_err = phaseErr_q;
   assign locked    = locked_q;

endmodule

// File: tb/tb_costas_loop_gen.sv
// Self-checking bench for costas_loop_gen: directed scenarios with literal
// expectations plus randomized traffic against an arithmetic reference model.
module tb_costas_loop_gen;

   localparam longint LIM  = 64'sd2147483647;
   localparam longint MASK = 64'hFFFF_FFFF;

   logic               clk = 1'b0;
   logic               resetN = 1'b1;
   logic               inValid = 1'b0;
   logic [31:0]        iIn = '0;
   logic [31:0]        qIn = '0;
   logic               modeSel = 1'b0;
   logic [31:0]        centerFreq = 32'h1000_0000;
   logic [31:0]        lockThresh = 32'd100;
   logic               freezeSig = 1'b0;
   logic               clearSig = 1'b0;
   logic [31:0]        carrierFreqOut;
   logic [31:0]        ncoPhase;
   logic               errValid;
   logic signed [32:0] phaseErr;
   logic               lockedOut;

   int errCount = 0;
   int checkCount = 0;

   longint mPhaseErr = 0;
   bit     mErrValid = 1'b0;
   longint mInteg = 0;
   longint mOffset = 0;
   bit     mLocked = 1'b0;
   int     mRun = 0;
   longint mNco = 0;

   costas_loop_gen dut (
      .clk              (clk),
      .reset            (resetN),
      .in_valid         (inValid),
      .i_in             (iIn),
      .q_in             (qIn),
      .mode             (modeSel),
      .center_freq      (centerFreq),
      .lock_thresh      (lockThresh),
      .freeze           (freezeSig),
      .clear            (clearSig),
      .carrier_freq_out (carrierFreqOut),
      .nco_phase        (ncoPhase),
      .err_valid        (errValid),
      .phase_err        (phaseErr),
      .locked           (lockedOut)
   );

   always #5 clk = ~clk;

   function automatic longint sgnOf(input longint x);
      return (x < 0) ? -64'sd1 : 64'sd1;
   endfunction

   function automatic longint floorDiv(input longint x, input longint d);
      return (x >= 0) ? x / d : -((-x + d - 1) / d);
   endfunction

   function automatic longint clampLim(input longint x);
      return (x > LIM) ? LIM : ((x < -LIM) ? -LIM : x);
   endfunction

   function automatic longint detectorErr(input logic [31:0] i, input logic [31:0] q, input logic md);
      longint iv, qv;
      iv = longint'($signed(i));
      qv = longint'($signed(q));
      return md ? qv * sgnOf(iv) : qv * sgnOf(iv) - iv * sgnOf(qv);
   endfunction

   function automatic longint expCarrier();
      return (longint'(centerFreq) - mOffset) & MASK;
   endfunction

   // Reference model: outputs follow from the loop equations directly.
   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         mPhaseErr <= 0;
         mErrValid <= 1'b0;
         mInteg    <= 0;
         mOffset   <= 0;
         mLocked   <= 1'b0;
         mRun      <= 0;
         mNco      <= 0;
      end else begin
         mNco <= (mNco + expCarrier()) & MASK;
         if (clearSig) begin
            mInteg  <= 0;
            mOffset <= 0;
            mRun    <= 0;
            mLocked <= 1'b0;
         end else if (mErrValid) begin
            if (freezeSig) begin
               mOffset <= mInteg;
            end else begin
               mInteg  <= clampLim(mInteg + floorDiv(mPhaseErr, 4096));
               mOffset <= clampLim(floorDiv(mPhaseErr, 128) + clampLim(mInteg + floorDiv(mPhaseErr, 4096)));
            end
            if ((((mPhaseErr < 0) ? -mPhaseErr : mPhaseErr) < longint'(lockThresh)) != mLocked) begin
               if (mRun + 1 == (mLocked ? 16 : 64)) begin
                  mLocked <= !mLocked;
                  mRun    <= 0;
               end else begin
                  mRun <= mRun + 1;
               end
            end else begin
               mRun <= 0;
            end
         end
         mErrValid <= inValid;
         if (inValid) begin
            mPhaseErr <= detectorErr(iIn, qIn, modeSel);
         end
      end
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checkCount++;
      if (actual != expected) begin
         errCount++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("carrier_freq_out", longint'(carrierFreqOut), expCarrier());
      checkOutput("nco_phase", longint'(ncoPhase), mNco);
      checkOutput("err_valid", longint'(errValid), longint'(mErrValid));
      checkOutput("phase_err", longint'(phaseErr), mPhaseErr);
      checkOutput("locked", longint'(lockedOut), longint'(mLocked));
   end

   task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [31:0] q, input logic md);
      inValid = v;
      iIn     = i;
      qIn     = q;
      modeSel = md;
      @(posedge clk);
      #2;
   endtask

   task automatic pulseClear();
      clearSig = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b0);
      clearSig = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      int iv, qv;
      #1 resetN = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset_carrier", longint'(carrierFreqOut), 64'h1000_0000);
      checkOutput("reset_nco", longint'(ncoPhase), 0);
      checkOutput("reset_locked", longint'(lockedOut), 0);
      resetN = 1'b1;
      @(posedge clk);
      #2;
      checkOutput("nco_first_step", longint'(ncoPhase), 64'h1000_0000);

      applyStimulus(1'b1, 32'd1000, 32'd300, 1'b0);
      checkOutput("qpsk_pos_i", longint'(phaseErr), -700);
      applyStimulus(1'b1, -32'sd1000, 32'd300, 1'b0);
      checkOutput("qpsk_neg_i", longint'(phaseErr), 700);
      applyStimulus(1'b1, 32'h8000_0000, 32'd0, 1'b0);
      checkOutput("qpsk_min_i", longint'(phaseErr), 64'sd2147483648);
      applyStimulus(1'b1, -32'sd500, 32'd200, 1'b1);
      checkOutput("bpsk_err", longint'(phaseErr), -200);
      checkOutput("err_valid_pulse", longint'(errValid), 1);

      pulseClear();
      applyStimulus(1'b1, 32'd1, 32'd4096, 1'b1);
      checkOutput("steady_err", longint'(phaseErr), 4096);
      applyStimulus(1'b1, 32'd1, 32'd4096, 1'b1);
      checkOutput("steady_carrier_1", longint'(carrierFreqOut), 64'h0FFF_FFDF);
      applyStimulus(1'b1, 32'd1, 32'd4096, 1'b1);
      checkOutput("steady_carrier_2", longint'(carrierFreqOut), 64'h0FFF_FFDE);

      repeat (4200) applyStimulus(1'b1, 32'h8000_0000, 32'd0, 1'b0);
      checkOutput("sat_carrier", longint'(carrierFreqOut), 64'h9000_0001);
      pulseClear();
      applyStimulus(1'b1, 32'd1, 32'd4096, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("post_clear_carrier", longint'(carrierFreqOut), 64'h0FFF_FFDF);

      pulseClear();
      applyStimulus(1'b1, 32'd0, 32'd5054464, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("pre_freeze_carrier", longint'(carrierFreqOut), 64'h1000_0000 - 40722);
      freezeSig = 1'b1;
      repeat (4) applyStimulus(1'b1, 32'd0, 32'd10000, 1'b0);
      checkOutput("freeze_carrier", longint'(carrierFreqOut), 64'h0FFF_FB2E);
      freezeSig = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b0);

      pulseClear();
      lockThresh = 32'd100;
      repeat (64) applyStimulus(1'b1, 32'd1, ($urandom_range(0, 1) != 0) ? 32'd50 : -32'sd50, 1'b1);
      checkOutput("lock_before_64th", longint'(lockedOut), 0);
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("lock_at_64th", longint'(lockedOut), 1);
      repeat (15) applyStimulus(1'b1, 32'd1, 32'd500, 1'b1);
      applyStimulus(1'b1, 32'd1, -32'sd50, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("lock_hold_15_out", longint'(lockedOut), 1);
      repeat (16) applyStimulus(1'b1, 32'd1, -32'sd500, 1'b1);
      checkOutput("lock_hold_before_16th", longint'(lockedOut), 1);
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("unlock_at_16th", longint'(lockedOut), 0);

      for (int n = 0; n < 3000; n++) begin
         freezeSig = ($urandom_range(0, 19) == 0);
         clearSig  = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 99) == 0) lockThresh = $urandom_range(0, 300);
         if (n == 700) centerFreq = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            iv = int'($urandom_range(0, 400)) - 200;
            qv = int'($urandom_range(0, 400)) - 200;
         end else begin
            iv = int'($urandom);
            qv = int'($urandom);
         end
         applyStimulus($urandom_range(0, 3) != 0, iv, qv, $urandom_range(0, 1) != 0);
         if (n == 1500) begin
            #1 resetN = 1'b0;
            @(negedge clk);
            checkOutput("midrun_reset_nco", longint'(ncoPhase), 0);
            checkOutput("midrun_reset_err_valid", longint'(errValid), 0);
            checkOutput("midrun_reset_locked", longint'(lockedOut), 0);
            @(posedge clk);
            #2 resetN = 1'b1;
         end
      end
      freezeSig = 1'b0;
      clearSig  = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
